// File: rtl/rank_insert_arbiter.sv
// Round-robin insert arbiter in front of a rank pipe.
// Each port owns a one-entry holding register; the winner feeds a registered output stage.
module rank_insert_arbiter #(
    parameter int NUM_PORTS         = 4,
    parameter int META_WIDTH        = 16,
    parameter int RANK_CODE_BITS    = 2,
    parameter int FLOW_ID_WIDTH     = 16,
    parameter int FLOW_WEIGHT_WIDTH = 8,
    parameter int NUM_RANK_OPS      = 2,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_PORTS-1:0]                   in_valid,
    output logic [NUM_PORTS-1:0]                   in_ready,
    input  logic [NUM_PORTS*META_WIDTH-1:0]        in_meta,
    input  logic [NUM_PORTS*RANK_CODE_BITS-1:0]    in_rank_op,
    input  logic [NUM_PORTS*FLOW_ID_WIDTH-1:0]     in_flowID,
    input  logic [NUM_PORTS*FLOW_WEIGHT_WIDTH-1:0] in_flow_weight,
    input  logic                                   busy,
    output logic                                   insert,
    output logic [META_WIDTH-1:0]                  meta_out,
    output logic [RANK_CODE_BITS-1:0]              rank_op_out,
    output logic [FLOW_ID_WIDTH-1:0]               flowID_out,
    output logic [FLOW_WEIGHT_WIDTH-1:0]           flow_weight_out,
    output logic [$clog2(NUM_PORTS)-1:0]           src_port_out,
    output logic [COUNT_WIDTH-1:0]                 insert_count
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam logic [PW:0] NP = (PW+1)'(NUM_PORTS);
    localparam logic [RANK_CODE_BITS:0] OPS_LIM = (RANK_CODE_BITS+1)'(NUM_RANK_OPS);

    logic [NUM_PORTS-1:0]         hold_valid_q;
    logic [META_WIDTH-1:0]        hold_meta_q [NUM_PORTS];
    logic [RANK_CODE_BITS-1:0]    hold_op_q   [NUM_PORTS];
    logic [FLOW_ID_WIDTH-1:0]     hold_fid_q  [NUM_PORTS];
    logic [FLOW_WEIGHT_WIDTH-1:0] hold_wt_q   [NUM_PORTS];
    logic [RANK_CODE_BITS-1:0]    op_clean    [NUM_PORTS];

    logic                         insert_q;
    logic [META_WIDTH-1:0]        meta_q;
    logic [RANK_CODE_BITS-1:0]    op_q;
    logic [FLOW_ID_WIDTH-1:0]     fid_q;
    logic [FLOW_WEIGHT_WIDTH-1:0] wt_q;
    logic [PW-1:0]                src_q;
    logic [PW-1:0]                rr_q, rr_d;
    logic [COUNT_WIDTH-1:0]       count_q;

    logic                 free, found;
    logic [PW-1:0]        gidx;
    logic [PW:0]          cand, nxt;
    logic [NUM_PORTS-1:0] grant, accept;

    assign free = ~insert_q | ~busy;

    // First holding register set at or above rr_q, wrapping past the top port
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, rr_q} + (PW+1)'(i);
            if (cand >= NP) cand = cand - NP;
            if (free && !found && hold_valid_q[cand[PW-1:0]]) begin
                found = 1'b1;
                gidx  = cand[PW-1:0];
                grant[cand[PW-1:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        nxt  = {1'b0, gidx} + (PW+1)'(1);
        rr_d = (nxt == NP) ? '0 : nxt[PW-1:0];
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            op_clean[p] = in_rank_op[p*RANK_CODE_BITS +: RANK_CODE_BITS];
            if ({1'b0, op_clean[p]} >= OPS_LIM) op_clean[p] = '0;
        end
    end

    assign in_ready = rst ? (~hold_valid_q | grant) : '0;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                hold_meta_q[p] <= '0;
                hold_op_q[p]   <= '0;
                hold_fid_q[p]  <= '0;
                hold_wt_q[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant[p]) hold_valid_q[p] <= 1'b0;
                if (accept[p]) begin
                    hold_valid_q[p] <= 1'b1;
                    hold_meta_q[p]  <= in_meta[p*META_WIDTH +: META_WIDTH];
                    hold_op_q[p]    <= op_clean[p];
                    hold_fid_q[p]   <= in_flowID[p*FLOW_ID_WIDTH +: FLOW_ID_WIDTH];
                    hold_wt_q[p]    <= in_flow_weight[p*FLOW_WEIGHT_WIDTH +: FLOW_WEIGHT_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            insert_q <= 1'b0;
            meta_q   <= '0;
            op_q     <= '0;
            fid_q    <= '0;
            wt_q     <= '0;
            src_q    <= '0;
            rr_q     <= '0;
            count_q  <= '0;
        end else begin
            if (found) begin
                insert_q <= 1'b1;
                meta_q   <= hold_meta_q[gidx];
                op_q     <= hold_op_q[gidx];
                fid_q    <= hold_fid_q[gidx];
                wt_q     <= hold_wt_q[gidx];
                src_q    <= gidx;
                rr_q     <= rr_d;
            end else if (free) begin
                insert_q <= 1'b0;
            end
            if (insert_q && !busy) count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

    assign insert          = insert_q;
    assign meta_out        = meta_q;
    assign rank_op_out     = op_q;
    assign flowID_out      = fid_q;
    assign flow_weight_out = wt_q;
    assign src_port_out    = src_q;
    assign insert_count    = count_q;

endmodule

// File: doc/rank_insert_arbiter.md
RANK_INSERT_ARBITER -- requirements
Module: rank_insert_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, giving the number of requester ports (2..8).
REQ-002 SHALL have parameters META_WIDTH=16, RANK_CODE_BITS=2, FLOW_ID_WIDTH=16, FLOW_WEIGHT_WIDTH=8, NUM_RANK_OPS=2, COUNT_WIDTH=32.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, NUM_PORTS bits: per-port request valid.
REQ-006 SHALL have port in_ready, output, NUM_PORTS bits: per-port accept.
REQ-007 SHALL have port in_meta, input, NUM_PORTS*META_WIDTH bits: per-port metadata; port p occupies bits [p*META_WIDTH +: META_WIDTH].
REQ-008 SHALL have ports in_rank_op, in_flowID and in_flow_weight, inputs, NUM_PORTS times their respective widths, packed the same way.
REQ-009 SHALL have port busy, input, 1 bit: downstream rank pipe cannot accept this cycle.
REQ-010 SHALL have port insert, output, 1 bit, registered: a downstream entry is presented.
REQ-011 SHALL have ports meta_out, rank_op_out, flowID_out and flow_weight_out, outputs, registered: the presented entry.
REQ-012 SHALL have port src_port_out, output, clog2(NUM_PORTS) bits, registered: the source port of the presented entry.
REQ-013 SHALL have port insert_count, output, COUNT_WIDTH bits: number of completed downstream transfers.

Function
REQ-014 SHALL give each port a 1-entry holding register with a flag hold_valid[p].
REQ-015 SHALL drive in_ready[p] as ~hold_valid[p] | grant[p], combinationally.
REQ-016 SHALL capture a port's fields into its holding register on a clock edge where in_valid[p] & in_ready[p]; a simultaneous grant and accept on the same port SHALL reload the register, with no bubble.
REQ-017 SHALL substitute rank_op 0 at capture when in_rank_op >= NUM_RANK_OPS, keeping all other fields unchanged.
REQ-018 SHALL define the output stage as free when ~insert | ~busy.
REQ-019 SHALL define a downstream transfer as the condition insert & ~busy.
REQ-020 SHALL, when the output stage is free, grant exactly one port: the first port with hold_valid set, searching upward from rr_ptr with wrap from NUM_PORTS-1 to 0.
REQ-021 SHALL grant no port when the output stage is not free or when no hold_valid bit is set.
REQ-022 SHALL, on a grant to port g, load the output registers from port g's holding register, set insert=1, set src_port_out=g, clear hold_valid[g] (unless it is reloaded per REQ-016), and set rr_ptr=(g+1) mod NUM_PORTS.
REQ-023 SHALL, when the output stage is free and there is no grant, clear insert to 0 and leave the data outputs holding their last value.
REQ-024 SHALL hold insert and all data outputs stable while insert & busy.
REQ-025 SHALL have a latency of 2 cycles: a request accepted in cycle k is presented with insert=1 in cycle k+2 at the earliest.
REQ-026 SHALL sustain a throughput of 1 transfer per cycle when busy=0 and requests are continuous.
REQ-027 SHALL leave rr_ptr unchanged in cycles without a grant.
REQ-028 SHALL increment insert_count on each transfer, wrapping modulo 2^COUNT_WIDTH.
REQ-029 SHALL never lose or duplicate an entry; each accepted request SHALL produce exactly one transfer.

Reset
REQ-030 SHALL, while rst=0, asynchronously clear hold_valid to all 0, insert to 0, all data outputs to 0, src_port_out to 0, rr_ptr to 0 and insert_count to 0.
REQ-031 SHALL force in_ready to 0 while rst=0.
REQ-032 SHALL discard held and in-flight entries when reset is asserted mid-operation; there SHALL be no partial transfer after reset deasserts.
REQ-033 SHALL accept requests from the first rising clk edge after rst returns to 1.

Verification
REQ-034 SHALL cover the single request: port 2 sends meta=0x00AA and rank_op=1 in cycle 0 with busy=0 -> insert=1, meta_out=0x00AA, src_port_out=2 in cycle 2, and insert_count=1.
REQ-035 SHALL cover fairness: all 4 ports valid continuously and busy=0 -> grant order 0,1,2,3,0,1... with 1 transfer per cycle and no port starved.
REQ-036 SHALL cover backpressure: busy=1 for 5 cycles with insert=1 -> outputs frozen; all in_ready bits fall once every hold_valid is set; after busy=0, the entries drain in RR order with none lost.
REQ-037 SHALL cover the invalid op: in_rank_op=3 with NUM_RANK_OPS=2 -> rank_op_out=0 while meta, flowID and weight are preserved.
REQ-038 SHALL cover reset mid-operation: rst=0 while insert=1 and 3 entries are held -> insert=0, insert_count=0, in_ready=0 immediately; after release, a single request follows REQ-034 timing from rr_ptr=0.
REQ-039 SHALL cover the counter wrap: insert_count preset near the limit via a COUNT_WIDTH=4 build, then 17 transfers -> insert_count=1.
